score_sseg_encoder: RTL

Upstream feeder for the eight-digit seven-segment controller in the pong example. It converts a binary score to four BCD digits using a sequential double-dabble, one bit per cycle. It then maps the digits to segment patterns and drives the controller's 64-bit val/mask/start interface. Each player's score occupies one 4-digit half of the display, and each update leaves the other half untouched.

---
 rtl/score_sseg_encoder_if.sv | 27 ++
 rtl/score_sseg_encoder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/score_sseg_encoder_if.sv
// Purpose : request/result bundle between a score source and the seven-segment encoder.
// Latency : n/a (wiring only).
// Backpressure: none; start_port is only honoured while busy is low and done_port is not pulsing.
// Ports   : start_port/value/side/blank_zeros (request), busy/done_port/out_start/val/mask (result).
interface score_sseg_encoder_if #(
    parameter int WIDTH = 14
);
    logic             start_port;
    logic [WIDTH-1:0] value;
    logic             side;
    logic             blank_zeros;
    logic             busy;
    logic             done_port;
    logic             out_start;
    logic [63:0]      val;
    logic [63:0]      mask;

    modport master (
        output start_port, value, side, blank_zeros,
        input  busy, done_port, out_start, val, mask
    );

    modport slave (
        input  start_port, value, side, blank_zeros,
        output busy, done_port, out_start, val, mask
    );
endinterface

// File: rtl/score_sseg_encoder.sv
// Purpose : binary score -> 4 BCD digits (serial double-dabble) -> segment bytes for one display half.
// Latency : out_start/done_port pulse in the 16th cycle after start_port is sampled (WIDTH=14).
// Backpressure: none; requests arriving while busy or during the done pulse are dropped.
// Ports   : clock, reset (async, active-high), bus (slave side of score_sseg_encoder_if).
module score_sseg_encoder #(
    parameter int WIDTH = 14
) (
    input  logic                 clock,
    input  logic                 reset,
    score_sseg_encoder_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        ENCODE,
        EMIT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] bin;
    logic [15:0]      bcd;
    logic [15:0]      bcd_adj;
    logic [3:0]       cnt;
    logic             ovf;
    logic             side_q;
    logic             blank_q;
    logic             busy_q;
    logic             done_q;
    logic             strobe_q;
    logic [63:0]      val_q;
    logic [63:0]      mask_q;
    logic [31:0]      half;
    logic             blank3;
    logic             blank2;
    logic             blank1;

    assign bus.busy      = busy_q;
    assign bus.done_port = done_q;
    assign bus.out_start = strobe_q;
    assign bus.val       = val_q;
    assign bus.mask      = mask_q;

    function automatic logic [7:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 8'h3F;
            4'd1:    seg = 8'h06;
            4'd2:    seg = 8'h5B;
            4'd3:    seg = 8'h4F;
            4'd4:    seg = 8'h66;
            4'd5:    seg = 8'h6D;
            4'd6:    seg = 8'h7D;
            4'd7:    seg = 8'h07;
            4'd8:    seg = 8'h7F;
            4'd9:    seg = 8'h6F;
            default: seg = 8'h00;
        endcase
    endfunction

    // Double-dabble correction applied before each shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero blanking ripples down from the thousands digit; ones is never blanked.
    always_comb begin
        blank3 = blank_q && (bcd[15:12] == 4'd0);
        blank2 = blank3  && (bcd[11:8]  == 4'd0);
        blank1 = blank2  && (bcd[7:4]   == 4'd0);
        if (ovf) begin
            half = 32'h4040_4040;
        end else begin
            half = {blank3 ? 8'h00 : seg(bcd[15:12]),
                    blank2 ? 8'h00 : seg(bcd[11:8]),
                    blank1 ? 8'h00 : seg(bcd[7:4]),
                    seg(bcd[3:0])};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            side_q   <= 1'b0;
            blank_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            strobe_q <= 1'b0;
            val_q    <= '0;
            mask_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_port) begin
                        bin     <= bus.value;
                        side_q  <= bus.side;
                        blank_q <= bus.blank_zeros;
                        ovf     <= ({{(32-WIDTH){1'b0}}, bus.value} > 32'd9999);
                        bcd     <= '0;
                        cnt     <= 4'(WIDTH);
                        busy_q  <= 1'b1;
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    // Only four digits are kept; overflowed values are dashed anyway.
                    bcd <= {bcd_adj[14:0], bin[WIDTH-1]};
                    bin <= bin << 1;
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ENCODE;
                    end
                end
                ENCODE: begin
                    val_q    <= side_q ? {half, 32'h0} : {32'h0, half};
                    mask_q   <= side_q ? 64'hFFFF_FFFF_0000_0000 : 64'h0000_0000_FFFF_FFFF;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    strobe_q <= 1'b1;
                    state    <= EMIT;
                end
                EMIT: begin
                    done_q   <= 1'b0;
                    strobe_q <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
